ex_muldiv: RTL and testbench
============================

# ex_muldiv

Multi-cycle multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline latch. It consumes the latched source operands (rdat1/rdat2) and a mult/div opcode, and computes the result iteratively into architectural HI/LO registers. While an operation is in flight it drives a stall that holds the ID/EX latch enable low.

## Interface
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  in  WIDTH  first operand: multiplicand, or dividend.
- rt_val  in  WIDTH  second operand: multiplier, or divisor.
- flush  in  1  abort any in-flight operation.
- busy  out  1  stall request to the pipeline (combinational).
- done  out  1  registered, one-cycle pulse: HI/LO were just written.
- div_zero  out  1  registered, one-cycle pulse alongside done when a DIV/DIVU had rt_val == 0.
- hi  out  WIDTH  HI register: upper product, or remainder.
- lo  out  WIDTH  LO register: lower product, or quotient.

## Operation
- FSM states:
  - IDLE: waits for start.
  - RUN: WIDTH iteration cycles.
  - FIX: one cycle of sign correction and HI/LO write.
- Start in IDLE (flush low):
  - Latch op and the operand magnitudes. For MULT/DIV these are two's-complement absolute values; for MULTU/DIVU they are the raw operands.
  - Latch the sign flags: product/quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - Load the iteration counter with WIDTH and go to RUN.
  - Exception: DIV/DIVU with rt_val == 0 goes straight to FIX.
- RUN, multiply:
  - Radix-2 shift-add into a 2*WIDTH accumulator.
  - Each cycle: if multiplier LSB is 1, add the multiplicand to the upper half; then shift right 1, keeping the carry.
- RUN, divide:
  - Restoring division, one quotient bit per cycle, MSB first.
  - Remainder register is WIDTH+1 bits.
- Counter decrements every RUN cycle. At 1 → FIX.
- FIX:
  - Apply two's-complement negation where the sign flags require it.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
  - Divide by zero: HI = rs_val as latched, LO = all ones.
  - Register done = 1 (and div_zero if applicable) for the next cycle; return to IDLE.
- busy = (state != IDLE) OR (start AND NOT flush). busy is low in the cycle done is high, so the pipeline advances.
- start while not IDLE: ignored.
- flush:
  - Forces IDLE at the next edge. HI/LO unchanged; no done.
  - flush and start in the same cycle: flush wins, nothing starts.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No exception.
- RST (any time, including mid-operation):
  - State IDLE; hi = 0, lo = 0, done = 0, div_zero = 0.
  - All internal registers cleared.
  - busy then follows the start input only.

## Timing
- Normal op, start high in cycle 0:
  - busy high in cycles 0..WIDTH+1.
  - RUN in cycles 1..WIDTH; FIX in cycle WIDTH+1.
  - hi/lo new and done = 1 in cycle WIDTH+2 (cycle 34 for WIDTH = 32).
- Divide by zero, start in cycle 0: FIX in cycle 1; done and div_zero high in cycle 2; busy high in cycles 0..1.
- hi/lo change only on the FIX → IDLE edge or on reset.
- A new start is accepted in the same cycle done is high (state is IDLE).

## Test plan
- MULT rs = 0xFFFFFFFE (−2), rt = 3, start at cycle 0 → cycle 34: hi = 0xFFFFFFFF, lo = 0xFFFFFFFA, done = 1; busy high exactly in cycles 0–33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001, done pulse one cycle wide.
- DIV rs = 0xFFFFFFF9 (−7), rt = 2 → lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1). Follow with DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU rs = 100, rt = 0 at cycle 0 → cycle 2: done = 1, div_zero = 1, hi = 0x00000064, lo = 0xFFFFFFFF.
- Two checks on the same preload (hi = 0x11111111, lo = 0x22222222):
  - MULTU started, flush at cycle 10 → busy low from cycle 11; no done; hi/lo unchanged. A new start at cycle 12 completes normally at cycle 46.
  - Same preload, start at cycle 0, then a second start at cycle 5 with different operands → second start ignored; the first result appears at cycle 34.
- RST asserted at cycle 15 of a DIV → hi = 0, lo = 0, done = 0, busy = 0 immediately (asynchronous); no done pulse after RST is released.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the execute stage: radix-2 shift-add multiply,
// restoring divide, sign fix-up on the final cycle, results held in HI/LO.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t r_state, w_next;

  logic               r_is_div, r_dz, r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_a;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;    // multiply: {partial, multiplier}; divide: low half dividend -> quotient
  logic [WIDTH:0]     r_rem;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_div_zero;

  logic               w_signed, w_div, w_rs_neg, w_rt_neg, w_start_ok, w_dz_start;
  logic [WIDTH-1:0]   w_rs_mag, w_rt_mag;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH+1:0]   w_dshift, w_ddiff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_remv;

  assign w_signed   = ~op[0];
  assign w_div      = op[1];
  assign w_rs_neg   = w_signed & rs_val[WIDTH-1];
  assign w_rt_neg   = w_signed & rt_val[WIDTH-1];
  assign w_rs_mag   = w_rs_neg ? (WIDTH'(0) - rs_val) : rs_val;
  assign w_rt_mag   = w_rt_neg ? (WIDTH'(0) - rt_val) : rt_val;
  assign w_start_ok = (r_state == S_IDLE) & start & ~flush;
  assign w_dz_start = w_div & ~(|rt_val);

  assign w_msum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  // Top bit of the shifted remainder is kept so a borrow is visible in w_ddiff's MSB.
  assign w_dshift = {r_rem, r_acc[WIDTH-1]};
  assign w_ddiff  = w_dshift - {2'b00, r_a};
  assign w_qbit   = ~w_ddiff[WIDTH+1];

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_q ? (WIDTH'(0) - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_remv = r_neg_r ? (WIDTH'(0) - r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next = w_dz_start ? S_FIX : S_RUN;
      S_RUN:  if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_comb begin
    busy = (r_state != S_IDLE) | (start & ~flush);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_is_div   <= 1'b0;
      r_dz       <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_a        <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: if (w_start_ok) begin
          r_is_div <= w_div;
          r_dz     <= w_div & w_dz_start;
          r_neg_q  <= w_rs_neg ^ w_rt_neg;
          r_neg_r  <= w_rs_neg;
          r_a      <= w_rt_mag;
          r_acc    <= {{WIDTH{1'b0}}, (w_div & w_dz_start) ? rs_val : w_rs_mag};
          r_rem    <= '0;
          r_cnt    <= CW'(WIDTH);
        end
        S_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_is_div) begin
            r_rem             <= w_qbit ? w_ddiff[WIDTH:0] : w_dshift[WIDTH:0];
            r_acc[WIDTH-1:0]  <= {r_acc[WIDTH-2:0], w_qbit};
          end else begin
            r_acc <= {w_msum, r_acc[WIDTH-1:1]};
          end
        end
        S_FIX: if (!flush) begin
          if (r_dz) begin
            r_hi <= r_acc[WIDTH-1:0];
            r_lo <= '1;
          end else if (r_is_div) begin
            r_hi <= w_remv;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done     <= 1'b1;
          r_div_zero <= r_dz;
        end
        default: ;
      endcase
    end
  end

  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed vectors feed a result scoreboard; a done-driven
// monitor pops and compares, while the driver checks busy/done timing per cycle.
module tb_ex_muldiv;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        start = 1'b0, flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int unsigned n_chk = 0, n_err = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;
  exp_t sb[$];

  ex_muldiv #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no result pending (hi=%h lo=%h)", hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
        chk("sb_div_zero", {31'b0, div_zero}, {31'b0, e.dz});
      end
    end
  end

  // Issue one op at cycle 0 and check busy/done every cycle up to the result.
  // k2 > 0 re-asserts start with different operands in that cycle (must be ignored).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz,
                        input int lat, input int k2);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = edz;
    sb.push_back(e);
    @(posedge CLK); #1;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge CLK);
    chk("busy_c0", {31'b0, busy}, 32'd1);
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      if (k == k2) begin
        start = 1'b1; op = DIVU; rs_val = 32'd99; rt_val = 32'd9;
      end
      @(negedge CLK);
      if (k < lat) begin
        if (busy !== 1'b1 || done !== 1'b0) begin
          chk($sformatf("busy_done_c%0d", k), {30'b0, busy, done}, 32'b10);
        end
      end else if (k == lat) begin
        chk("done_at_lat", {30'b0, busy, done}, 32'b01);
      end else begin
        chk("done_one_cycle", {31'b0, done}, 32'd0);
      end
    end
  endtask

  initial begin
    #12;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_done", {30'b0, done, div_zero}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    start = 1'b1; #1;
    chk("rst_busy_start", {31'b0, busy}, 32'd1);
    flush = 1'b1; #1;
    chk("rst_busy_flush", {31'b0, busy}, 32'd0);
    start = 1'b0; flush = 1'b0;
    @(posedge CLK); #1 RST = 1'b0;

    run_op(MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 34, 0);
    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 0);
    run_op(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 0);
    run_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 0);
    run_op(DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 2,  0);
    run_op(DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 2,  0);
    run_op(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 0);
    run_op(MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, 34, 0);
    run_op(DIVU,  32'd1000,     32'd7,        32'd6,        32'd142,      1'b0, 34, 0);
    run_op(DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34, 0);

    // Flush mid-run: preload HI/LO, abort at cycle 10, restart at cycle 12.
    run_op(MULTU, 32'h22222222, 32'h80000001, 32'h11111111, 32'h22222222, 1'b0, 34, 0);
    @(posedge CLK); #1;
    start = 1'b1; op = MULTU; rs_val = 32'd5; rt_val = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      if (k == 10) flush = 1'b1;
    end
    @(negedge CLK);
    chk("flush_busy_c10", {31'b0, busy}, 32'd1);
    @(posedge CLK); #1 flush = 1'b0;
    @(negedge CLK);
    chk("flush_busy_c11", {31'b0, busy}, 32'd0);
    chk("flush_hi_kept", hi, 32'h11111111);
    chk("flush_lo_kept", lo, 32'h22222222);
    run_op(MULTU, 32'd5, 32'd7, 32'd0, 32'd35, 1'b0, 34, 0);

    // Second start during an in-flight op is ignored.
    run_op(MULTU, 32'h22222222, 32'h80000001, 32'h11111111, 32'h22222222, 1'b0, 34, 0);
    run_op(MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, 5);

    run_op(DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 1'b0, 34, 0);

    // Asynchronous reset in the middle of a divide.
    @(posedge CLK); #1;
    start = 1'b1; op = DIV; rs_val = 32'd1000; rt_val = 32'd3;
    for (int k = 1; k <= 15; k++) begin
      @(posedge CLK); #1;
      start = 1'b0;
    end
    #2 RST = 1'b1;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    repeat (40) @(negedge CLK);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_lo", lo, 32'h0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
